grid_io_multi_cfg: RTL and testbench

//   Parametrised I/O grid tile with NUM_IO GPIO subtiles programmed over the ccff chain.

---
 rtl/grid_io_pkg.sv | 22 ++
 rtl/grid_io_multi_cfg_pad.sv | 32 +++
 rtl/grid_io_multi_cfg.sv | 85 ++++++++
 tb/tb_grid_io_multi_cfg.sv | 196 +++++++++++++++++++
 4 files changed

// File: rtl/grid_io_pkg.sv
// Shared types and sizing for the GPIO grid tile.
// CCFF_PARITY_EN adds one even-parity bit to the config chain.
package grid_io_pkg;

  localparam int MODE_BITS = 2;

  typedef enum logic [MODE_BITS-1:0] {
    IO_DIS  = 2'b00,
    IO_IN   = 2'b01,
    IO_OUT  = 2'b10,
    IO_LOOP = 2'b11
  } io_mode_e;

  function automatic int chain_len(input int num_io);
`ifdef CCFF_PARITY_EN
    return num_io * MODE_BITS + 1;
`else
    return num_io * MODE_BITS;
`endif
  endfunction

endpackage

// File: rtl/grid_io_multi_cfg_pad.sv
// One GPIO subtile: mode decode and tristate pad driver.
// Purely combinational; the mode comes from the shadow register.
module io_pad_cell
  import grid_io_pkg::*;
(
  input  io_mode_e mode,
  input  logic     outpad,
  output logic     inpad,
  inout  wire      pad
);

  logic drive;
  logic sense;

  always_comb begin
    drive = 1'b0;
    sense = 1'b0;
    unique case (1'b1)
      (mode == IO_IN): sense = 1'b1;
      (mode == IO_OUT): drive = 1'b1;
      (mode == IO_LOOP): begin
        drive = 1'b1;
        sense = 1'b1;
      end
      default: ;
    endcase
  end

  assign pad   = drive ? outpad : 1'bz;
  assign inpad = sense ? pad : 1'b0;

endmodule

// File: rtl/grid_io_multi_cfg.sv
// I/O grid tile: ccff shift chain, load counter, shadow config.
// CCFF_PARITY_EN enables the parity bit and cfg_err.
module grid_io_multi_cfg
  import grid_io_pkg::*;
#(
  parameter int NUM_IO = 4
) (
  input  logic              prog_clk,
  input  logic              pReset_n,
  input  logic              ccff_en,
  input  logic              ccff_head,
  output logic              ccff_tail,
  output logic              cfg_done,
  output logic              cfg_err,
  inout  wire  [NUM_IO-1:0] gfpga_pad_GPIO_PAD,
  input  logic [NUM_IO-1:0] outpad,
  output logic [NUM_IO-1:0] inpad
);

  localparam int CFG_W = NUM_IO * MODE_BITS;
  localparam int LEN   = chain_len(NUM_IO);
  localparam int CW    = $clog2(LEN + 1);
  localparam logic [CW-1:0] CNT_LAST = CW'(LEN - 1);
  localparam logic [CW-1:0] CNT_FULL = CW'(LEN);

  logic [LEN-1:0]   sr;
  logic [LEN-1:0]   sr_next;
  logic [CW-1:0]    cnt;
  logic [CFG_W-1:0] shadow;
  logic             complete;
  logic             parity_ok;

  assign sr_next  = {sr[LEN-2:0], ccff_head};
  assign complete = ccff_en && (cnt == CNT_LAST);
  assign ccff_tail = sr[LEN-1];

`ifdef CCFF_PARITY_EN
  assign parity_ok = ~^sr_next;

  always_ff @(posedge prog_clk or negedge pReset_n) begin
    if (!pReset_n) begin
      cfg_err <= 1'b0;
    end else if (complete) begin
      cfg_err <= !parity_ok;
    end
  end
`else
  assign parity_ok = 1'b1;
  assign cfg_err   = 1'b0;
`endif

  // A full count means the previous load finished; new shifting restarts it
  always_ff @(posedge prog_clk or negedge pReset_n) begin
    if (!pReset_n) begin
      sr       <= '0;
      cnt      <= '0;
      shadow   <= '0;
      cfg_done <= 1'b0;
    end else if (ccff_en) begin
      sr <= sr_next;
      if (cnt == CNT_FULL) begin
        cnt      <= CW'(1);
        cfg_done <= 1'b0;
      end else begin
        cnt <= cnt + 1'b1;
      end
      if (complete) begin
        cfg_done <= parity_ok;
        if (parity_ok) begin
          shadow <= sr_next[CFG_W-1:0];
        end
      end
    end
  end

  for (genvar k = 0; k < NUM_IO; k++) begin : g_io
    io_pad_cell u_cell (
      .mode   (io_mode_e'(shadow[MODE_BITS*k +: MODE_BITS])),
      .outpad (outpad[k]),
      .inpad  (inpad[k]),
      .pad    (gfpga_pad_GPIO_PAD[k])
    );
  end

endmodule

// File: tb/tb_grid_io_multi_cfg.sv
// Bench for grid_io_multi_cfg with NUM_IO=2 and a queue-based model.
// Honours CCFF_PARITY_EN when the design is built with it.
module tb_grid_io_multi_cfg;
  import grid_io_pkg::*;

  localparam int NUM_IO = 2;
  localparam int CFG_W  = NUM_IO * MODE_BITS;
  localparam int LEN    = chain_len(NUM_IO);

  logic prog_clk  = 1'b0;
  logic pReset_n  = 1'b0;
  logic ccff_en   = 1'b0;
  logic ccff_head = 1'b0;
  logic ccff_tail;
  logic cfg_done;
  logic cfg_err;
  wire  [NUM_IO-1:0] pad;
  logic [NUM_IO-1:0] outpad     = '0;
  logic [NUM_IO-1:0] inpad;
  logic [NUM_IO-1:0] tb_pad_val = '0;
  logic [NUM_IO-1:0] tb_drv_en  = '1;

  int compared   = 0;
  int mismatched = 0;

  bit               hist[$];
  int               load_bits = 0;
  bit               m_done    = 1'b0;
  bit               m_err     = 1'b0;
  logic [CFG_W-1:0] m_shadow  = '0;

  always #5 prog_clk = ~prog_clk;

  for (genvar i = 0; i < NUM_IO; i++) begin : g_drv
    assign pad[i] = tb_drv_en[i] ? tb_pad_val[i] : 1'bz;
  end

  grid_io_multi_cfg #(.NUM_IO(NUM_IO)) dut (
    .prog_clk           (prog_clk),
    .pReset_n           (pReset_n),
    .ccff_en            (ccff_en),
    .ccff_head          (ccff_head),
    .ccff_tail          (ccff_tail),
    .cfg_done           (cfg_done),
    .cfg_err            (cfg_err),
    .gfpga_pad_GPIO_PAD (pad),
    .outpad             (outpad),
    .inpad              (inpad)
  );

  function automatic io_mode_e mode_of(int k);
    return io_mode_e'(m_shadow[MODE_BITS*k +: MODE_BITS]);
  endfunction

  task automatic set_drive();
    for (int k = 0; k < NUM_IO; k++) begin
      tb_drv_en[k] = !(mode_of(k) inside {IO_OUT, IO_LOOP});
    end
  endtask

  task automatic chk(string tag, logic [31:0] obs, logic [31:0] exp);
    compared++;
    assert (obs === exp) else begin
      mismatched++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic check_all(string tag);
    logic exp_pad, exp_in;
    io_mode_e m;
    chk({tag, " done"}, 32'(cfg_done), 32'(m_done));
    chk({tag, " err"}, 32'(cfg_err), 32'(m_err));
    if (hist.size() >= LEN) begin
      chk({tag, " tail"}, 32'(ccff_tail), 32'(hist[hist.size() - LEN]));
    end else begin
      chk({tag, " tail"}, 32'(ccff_tail), 32'(0));
    end
    for (int k = 0; k < NUM_IO; k++) begin
      m = mode_of(k);
      exp_pad = (m == IO_OUT || m == IO_LOOP) ? outpad[k] : tb_pad_val[k];
      if (m == IO_IN) exp_in = tb_pad_val[k];
      else if (m == IO_LOOP) exp_in = outpad[k];
      else exp_in = 1'b0;
      chk($sformatf("%s pad%0d", tag, k), 32'(pad[k]), 32'(exp_pad));
      chk($sformatf("%s inpad%0d", tag, k), 32'(inpad[k]), 32'(exp_in));
    end
  endtask

  task automatic model_shift(bit b);
    logic [31:0] word;
    bit good;
    hist.push_back(b);
    if (load_bits == LEN) begin
      load_bits = 1;
      m_done = 1'b0;
    end else begin
      load_bits++;
    end
    if (load_bits == LEN) begin
      word = '0;
      for (int j = 0; j < LEN; j++) word[j] = hist[hist.size() - 1 - j];
`ifdef CCFF_PARITY_EN
      good = ($countones(word) % 2) == 0;
      m_err = !good;
`else
      good = 1'b1;
`endif
      if (good) m_shadow = word[CFG_W-1:0];
      m_done = good;
    end
  endtask

  task automatic tick(bit en, bit head, logic [NUM_IO-1:0] ov,
                      logic [NUM_IO-1:0] pv, string tag);
    ccff_en = en;
    ccff_head = head;
    outpad = ov;
    tb_pad_val = pv;
    @(posedge prog_clk);
    if (en) model_shift(head);
    set_drive();
    @(negedge prog_clk);
    check_all(tag);
  endtask

  task automatic rtick(bit en, bit head, string tag);
    tick(en, head, NUM_IO'($urandom), NUM_IO'($urandom), tag);
  endtask

  task automatic load(logic [31:0] v, int n, string tag);
    for (int i = n - 1; i >= 0; i--) rtick(1'b1, v[i], tag);
  endtask

  task automatic do_reset(string tag);
    pReset_n = 1'b0;
    ccff_en = 1'b0;
    tb_pad_val = NUM_IO'($urandom);
    #1;
    hist.delete();
    load_bits = 0;
    m_done = 1'b0;
    m_err = 1'b0;
    m_shadow = '0;
    set_drive();
    #1;
    check_all(tag);
    @(negedge prog_clk);
    pReset_n = 1'b1;
  endtask

  initial begin
    @(negedge prog_clk);
    do_reset("t1 reset");
    chk("t1 inpad", 32'(inpad), 32'(0));

    load(32'b1001, LEN, "t2 load");
    tick(1'b0, 1'b0, 2'b10, 2'b01, "t2 apply");
    chk("t2 done", 32'(cfg_done), 32'(1));
    chk("t2 pad1", 32'(pad[1]), 32'(1));
    chk("t2 inpad", 32'(inpad), 32'(2'b01));

    rtick(1'b1, 1'b1, "t3 shift");
    rtick(1'b1, 1'b0, "t3 shift");
    for (int i = 0; i < 3; i++) rtick(1'b0, 1'b1, "t3 hold");
    tick(1'b0, 1'b0, 2'b10, 2'b01, "t3 keep");
    chk("t3 done", 32'(cfg_done), 32'(0));
    chk("t3 inpad", 32'(inpad), 32'(2'b01));

    load(32'b011, 3, "t4 part");
    do_reset("t4 reset");
    load(32'($urandom) & 32'hC, LEN, "t4 fresh");

    do_reset("t5 reset");
    load(32'b1011_0110, 8, "t5 pass");
    for (int i = 0; i < LEN; i++) rtick(1'b0, 1'b0, "t5 hold");

`ifdef CCFF_PARITY_EN
    load(32'b1001, LEN, "t6 good");
    load(32'b10110, LEN, "t6 bad");
    chk("t6 err", 32'(cfg_err), 32'(1));
    chk("t6 done", 32'(cfg_done), 32'(0));
    load(32'b00110, LEN, "t6 fix");
    chk("t6 clr", 32'(cfg_err), 32'(0));
`endif

    for (int i = 0; i < 120; i++) begin
      rtick($urandom_range(0, 3) != 0, 1'($urandom), "rand");
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             compared, mismatched);
    $finish;
  end

endmodule
